// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM with ready-based memory handshake, timeout trap and retire counter.
// Latency: outputs are combinational from state (plus i_mem_ready in memory states); next state on each i_clk edge.
// Backpressure: FETCH/MEM_READ/MEM_WRITE hold while i_mem_ready=0, trapping after MEM_TIMEOUT held cycles.
module mc_ctrl_fsm #(
    parameter int RET_W       = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [5:0]       i_opcode,
    input  logic             i_mem_ready,
    output logic             o_memreq,
    output logic             o_iord,
    output logic             o_memwrite,
    output logic             o_irwrite,
    output logic             o_pcwrite,
    output logic             o_branch,
    output logic             o_branch_ne,
    output logic [1:0]       o_pcsrc,
    output logic [1:0]       o_regdst,
    output logic [1:0]       o_memtoreg,
    output logic [2:0]       o_aluop,
    output logic             o_alusrca,
    output logic [1:0]       o_alusrcb,
    output logic             o_regwrite,
    output logic             o_trap,
    output logic [1:0]       o_trap_cause,
    output logic [RET_W-1:0] o_retired,
    output logic [3:0]       o_state
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADR   = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_EXECUTE   = 4'd7;
    localparam logic [3:0] S_ALU_WB    = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_BRANCH_NE = 4'd10;
    localparam logic [3:0] S_I_EX      = 4'd11;
    localparam logic [3:0] S_I_WB      = 4'd12;
    localparam logic [3:0] S_JUMP      = 4'd13;
    localparam logic [3:0] S_JAL       = 4'd14;
    localparam logic [3:0] S_TRAP      = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [TO_W-1:0]  wait_cnt;
    logic [1:0]       cause;
    logic [RET_W-1:0] retired;
    logic             mem_state;
    logic             mem_timeout;
    logic             nxt_is_mem;

    // Memory-handshake states share the wait counter; timeout fires on the last allowed non-ready cycle.
    assign mem_state   = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    assign nxt_is_mem  = (state_nxt == S_FETCH) || (state_nxt == S_MEM_READ) || (state_nxt == S_MEM_WRITE);
    assign mem_timeout = mem_state && !i_mem_ready && (wait_cnt == WAIT_LAST);

    assign o_state      = state;
    assign o_trap_cause = cause;
    assign o_retired    = retired;

    // Next-state selection; ready takes priority over timeout in memory states.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      state_nxt = S_FETCH;
            S_FETCH: begin
                if (i_mem_ready)      state_nxt = S_DECODE;
                else if (mem_timeout) state_nxt = S_TRAP;
            end
            S_DECODE: begin
                case (i_opcode)
                    OP_RTYPE:                          state_nxt = S_EXECUTE;
                    OP_LW, OP_SW:                      state_nxt = S_MEM_ADR;
                    OP_BEQ:                            state_nxt = S_BRANCH;
                    OP_BNE:                            state_nxt = S_BRANCH_NE;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_nxt = S_I_EX;
                    OP_J:                              state_nxt = S_JUMP;
                    OP_JAL:                            state_nxt = S_JAL;
                    default:                           state_nxt = S_TRAP;
                endcase
            end
            S_MEM_ADR:   state_nxt = (i_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (i_mem_ready)      state_nxt = S_MEM_WB;
                else if (mem_timeout) state_nxt = S_TRAP;
            end
            S_MEM_WB:    state_nxt = S_FETCH;
            S_MEM_WRITE: begin
                if (i_mem_ready)      state_nxt = S_FETCH;
                else if (mem_timeout) state_nxt = S_TRAP;
            end
            S_EXECUTE:   state_nxt = S_ALU_WB;
            S_ALU_WB:    state_nxt = S_FETCH;
            S_BRANCH:    state_nxt = S_FETCH;
            S_BRANCH_NE: state_nxt = S_FETCH;
            S_I_EX:      state_nxt = S_I_WB;
            S_I_WB:      state_nxt = S_FETCH;
            S_JUMP:      state_nxt = S_FETCH;
            S_JAL:       state_nxt = S_FETCH;
            S_TRAP:      state_nxt = S_TRAP;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // State, wait counter, sticky trap cause and retire counter, all with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            cause    <= CAUSE_NONE;
            retired  <= '0;
        end else begin
            state <= state_nxt;

            if (nxt_is_mem && (state_nxt != state))
                wait_cnt <= '0;
            else if (mem_state && !i_mem_ready)
                wait_cnt <= wait_cnt + TO_W'(1);

            if ((state == S_DECODE) && (state_nxt == S_TRAP))
                cause <= CAUSE_ILLEGAL;
            else if (mem_timeout)
                cause <= CAUSE_TIMEOUT;

            // An instruction retires when it hands control back to FETCH; the IDLE start-up does not count.
            if ((state_nxt == S_FETCH) && (state != S_FETCH) && (state != S_IDLE))
                retired <= retired + RET_W'(1);
        end
    end

    // Datapath controls; everything is held low during reset so an aborted access cannot write.
    always_comb begin
        o_memreq    = 1'b0;
        o_iord      = 1'b0;
        o_memwrite  = 1'b0;
        o_irwrite   = 1'b0;
        o_pcwrite   = 1'b0;
        o_branch    = 1'b0;
        o_branch_ne = 1'b0;
        o_pcsrc     = 2'b00;
        o_regdst    = 2'b00;
        o_memtoreg  = 2'b00;
        o_aluop     = 3'b000;
        o_alusrca   = 1'b0;
        o_alusrcb   = 2'b00;
        o_regwrite  = 1'b0;
        o_trap      = 1'b0;
        if (i_reset) begin
            case (state)
                S_FETCH: begin
                    o_memreq  = 1'b1;
                    o_alusrcb = 2'b01;
                    o_irwrite = i_mem_ready;
                    o_pcwrite = i_mem_ready;
                end
                S_DECODE:    o_alusrcb = 2'b11;
                S_MEM_ADR: begin
                    o_alusrca = 1'b1;
                    o_alusrcb = 2'b10;
                end
                S_MEM_READ: begin
                    o_memreq = 1'b1;
                    o_iord   = 1'b1;
                end
                S_MEM_WB: begin
                    o_memtoreg = 2'b01;
                    o_regwrite = 1'b1;
                end
                S_MEM_WRITE: begin
                    o_memreq   = 1'b1;
                    o_iord     = 1'b1;
                    o_memwrite = 1'b1;
                end
                S_EXECUTE: begin
                    o_alusrca = 1'b1;
                    o_aluop   = 3'b010;
                end
                S_ALU_WB: begin
                    o_regdst   = 2'b01;
                    o_regwrite = 1'b1;
                end
                S_BRANCH: begin
                    o_alusrca = 1'b1;
                    o_aluop   = 3'b001;
                    o_pcsrc   = 2'b01;
                    o_branch  = 1'b1;
                end
                S_BRANCH_NE: begin
                    o_alusrca   = 1'b1;
                    o_aluop     = 3'b001;
                    o_pcsrc     = 2'b01;
                    o_branch_ne = 1'b1;
                end
                S_I_EX: begin
                    o_alusrca = 1'b1;
                    o_alusrcb = 2'b10;
                    case (i_opcode)
                        OP_ANDI: o_aluop = 3'b011;
                        OP_ORI:  o_aluop = 3'b100;
                        OP_SLTI: o_aluop = 3'b101;
                        default: o_aluop = 3'b000;
                    endcase
                end
                S_I_WB:      o_regwrite = 1'b1;
                S_JUMP: begin
                    o_pcsrc   = 2'b10;
                    o_pcwrite = 1'b1;
                end
                S_JAL: begin
                    o_regdst   = 2'b10;
                    o_memtoreg = 2'b10;
                    o_regwrite = 1'b1;
                    o_pcsrc    = 2'b10;
                    o_pcwrite  = 1'b1;
                end
                S_TRAP:      o_trap = 1'b1;
                default: ;
            endcase
            // The cycle that trips the timeout must not complete or launch any access.
            if (mem_timeout) begin
                o_memreq   = 1'b0;
                o_memwrite = 1'b0;
                o_irwrite  = 1'b0;
                o_pcwrite  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    localparam int TB_RET_W = 3;
    localparam int TB_TO    = 4;
    localparam int TB_TO_W  = 3;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEM_ADR = 3, ST_MEM_READ = 4;
    localparam int ST_MEM_WB = 5, ST_MEM_WRITE = 6, ST_EXECUTE = 7, ST_ALU_WB = 8, ST_BRANCH = 9;
    localparam int ST_BRANCH_NE = 10, ST_I_EX = 11, ST_I_WB = 12, ST_JUMP = 13, ST_JAL = 14, ST_TRAP = 15;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011;

    logic                i_clk = 1'b0;
    logic                i_reset;
    logic [5:0]          i_opcode;
    logic                i_mem_ready;
    logic                o_memreq, o_iord, o_memwrite, o_irwrite, o_pcwrite, o_branch, o_branch_ne;
    logic [1:0]          o_pcsrc, o_regdst, o_memtoreg, o_alusrcb, o_trap_cause;
    logic [2:0]          o_aluop;
    logic                o_alusrca, o_regwrite, o_trap;
    logic [TB_RET_W-1:0] o_retired;
    logic [3:0]          o_state;

    mc_ctrl_fsm #(.RET_W(TB_RET_W), .MEM_TIMEOUT(TB_TO), .TO_W(TB_TO_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_opcode(i_opcode), .i_mem_ready(i_mem_ready),
        .o_memreq(o_memreq), .o_iord(o_iord), .o_memwrite(o_memwrite), .o_irwrite(o_irwrite),
        .o_pcwrite(o_pcwrite), .o_branch(o_branch), .o_branch_ne(o_branch_ne), .o_pcsrc(o_pcsrc),
        .o_regdst(o_regdst), .o_memtoreg(o_memtoreg), .o_aluop(o_aluop), .o_alusrca(o_alusrca),
        .o_alusrcb(o_alusrcb), .o_regwrite(o_regwrite), .o_trap(o_trap), .o_trap_cause(o_trap_cause),
        .o_retired(o_retired), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       memreq, iord, memwrite, irwrite, pcwrite, branch, branch_ne;
        logic [1:0] pcsrc, regdst, memtoreg;
        logic [2:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       regwrite, trap;
    } ctl_t;

    ctl_t got_ctl;
    assign got_ctl = {o_memreq, o_iord, o_memwrite, o_irwrite, o_pcwrite, o_branch, o_branch_ne,
                      o_pcsrc, o_regdst, o_memtoreg, o_aluop, o_alusrca, o_alusrcb, o_regwrite, o_trap};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Each instruction is a list of post-FETCH steps; memory steps wait on ready with a cycle budget.
    int m_st, m_wait, m_cause, m_ret;
    int path[$];

    task automatic load_path(input logic [5:0] op);
        path.delete();
        path.push_back(ST_DECODE);
        case (op)
            OP_R:                            begin path.push_back(ST_EXECUTE); path.push_back(ST_ALU_WB); end
            OP_LW:                           begin path.push_back(ST_MEM_ADR); path.push_back(ST_MEM_READ); path.push_back(ST_MEM_WB); end
            OP_SW:                           begin path.push_back(ST_MEM_ADR); path.push_back(ST_MEM_WRITE); end
            OP_BEQ:                          path.push_back(ST_BRANCH);
            OP_BNE:                          path.push_back(ST_BRANCH_NE);
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin path.push_back(ST_I_EX); path.push_back(ST_I_WB); end
            OP_J:                            path.push_back(ST_JUMP);
            OP_JAL:                          path.push_back(ST_JAL);
            default:                         path.push_back(ST_TRAP);
        endcase
    endtask

    function automatic bit is_mem(input int s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

    task automatic model_advance();
        if (m_st == ST_FETCH) load_path(i_opcode);
        if (path.size() == 0) begin
            m_st  = ST_FETCH;
            m_ret = (m_ret + 1) % (1 << TB_RET_W);
        end else begin
            m_st = path.pop_front();
            if (m_st == ST_TRAP) m_cause = 1;
        end
        if (is_mem(m_st)) m_wait = 0;
    endtask

    task automatic model_step();
        if (!i_reset) begin
            m_st = ST_IDLE; m_wait = 0; m_cause = 0; m_ret = 0; path.delete();
        end else if (m_st == ST_IDLE) begin
            m_st = ST_FETCH; m_wait = 0;
        end else if (m_st == ST_TRAP) begin
            m_st = ST_TRAP;
        end else if (is_mem(m_st)) begin
            if (i_mem_ready) model_advance();
            else if (m_wait == TB_TO - 1) begin m_st = ST_TRAP; m_cause = 2; end
            else m_wait++;
        end else begin
            model_advance();
        end
    endtask

    function automatic ctl_t exp_out(input int st, input logic [5:0] op, input logic rdy, input int wt, input logic rst);
        ctl_t c;
        c = '0;
        if (!rst) return c;
        case (st)
            ST_FETCH:     begin c.memreq = 1; c.alusrcb = 2'b01; c.irwrite = rdy; c.pcwrite = rdy; end
            ST_DECODE:    c.alusrcb = 2'b11;
            ST_MEM_ADR:   begin c.alusrca = 1; c.alusrcb = 2'b10; end
            ST_MEM_READ:  begin c.memreq = 1; c.iord = 1; end
            ST_MEM_WB:    begin c.memtoreg = 2'b01; c.regwrite = 1; end
            ST_MEM_WRITE: begin c.memreq = 1; c.iord = 1; c.memwrite = 1; end
            ST_EXECUTE:   begin c.alusrca = 1; c.aluop = 3'b010; end
            ST_ALU_WB:    begin c.regdst = 2'b01; c.regwrite = 1; end
            ST_BRANCH:    begin c.alusrca = 1; c.aluop = 3'b001; c.pcsrc = 2'b01; c.branch = 1; end
            ST_BRANCH_NE: begin c.alusrca = 1; c.aluop = 3'b001; c.pcsrc = 2'b01; c.branch_ne = 1; end
            ST_I_EX: begin
                c.alusrca = 1; c.alusrcb = 2'b10;
                c.aluop = (op == OP_ANDI) ? 3'b011 : (op == OP_ORI) ? 3'b100 : (op == OP_SLTI) ? 3'b101 : 3'b000;
            end
            ST_I_WB:      c.regwrite = 1;
            ST_JUMP:      begin c.pcsrc = 2'b10; c.pcwrite = 1; end
            ST_JAL:       begin c.regdst = 2'b10; c.memtoreg = 2'b10; c.regwrite = 1; c.pcsrc = 2'b10; c.pcwrite = 1; end
            ST_TRAP:      c.trap = 1;
            default: ;
        endcase
        if (is_mem(st) && !rdy && wt == TB_TO - 1) begin
            c.memreq = 0; c.memwrite = 0; c.irwrite = 0; c.pcwrite = 0;
        end
        return c;
    endfunction

    // Compare DUT against model for the current inputs, then advance one clock.
    task automatic tick();
        ctl_t e;
        #1;
        e = exp_out(m_st, i_opcode, i_mem_ready, m_wait, i_reset);
        chk("model_state", 32'(o_state), 32'(m_st));
        chk("model_ctl", 32'(got_ctl), 32'(e));
        chk("model_cause", 32'(o_trap_cause), 32'(m_cause));
        chk("model_retired", 32'(o_retired), 32'(m_ret));
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
    endtask

    task automatic go_to_mem_write();
        do_reset();
        i_opcode = OP_SW; i_mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();   // IDLE, FETCH, DECODE, MEM_ADR
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
        logic       pcwrite, regwrite, branch, branch_ne;
        logic [1:0] pcsrc, regdst, memtoreg;
        logic [2:0] aluop;
        int         ret;
    } vec_t;

    vec_t vecs[13];
    logic [5:0] ops[12];

    initial begin
        int pulses, ret_before, burst;
        logic [12:0] got_sub, exp_sub;

        vecs[0]  = '{1'b0, OP_R,   1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 0};
        vecs[1]  = '{1'b1, OP_R,   1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 0};
        vecs[2]  = '{1'b1, OP_R,   1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 0};
        vecs[3]  = '{1'b1, OP_R,   1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 0};
        vecs[4]  = '{1'b1, OP_R,   1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 0};
        vecs[5]  = '{1'b1, OP_R,   1'b1, 4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 3'b000, 0};
        vecs[6]  = '{1'b1, OP_BNE, 1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1};
        vecs[7]  = '{1'b1, OP_BNE, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1};
        vecs[8]  = '{1'b1, OP_BNE, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b001, 1};
        vecs[9]  = '{1'b1, OP_JAL, 1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2};
        vecs[10] = '{1'b1, OP_JAL, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2};
        vecs[11] = '{1'b1, OP_JAL, 1'b1, 4'd14, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 2'b10, 3'b000, 2};
        vecs[12] = '{1'b1, OP_JAL, 1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3};

        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J, OP_JAL, 6'b111111};

        // Bring the DUT out of its unknown power-up state before any comparison.
        i_reset = 1'b0; i_opcode = OP_R; i_mem_ready = 1'b1;
        m_st = ST_IDLE; m_wait = 0; m_cause = 0; m_ret = 0;
        @(posedge i_clk); #1;

        // R-type, BNE, JAL with memory always ready.
        for (int i = 0; i < 13; i++) begin
            i_reset = vecs[i].rst; i_opcode = vecs[i].op; i_mem_ready = vecs[i].rdy;
            #1;
            got_sub = {o_pcwrite, o_regwrite, o_branch, o_branch_ne, o_pcsrc, o_regdst, o_memtoreg, o_aluop};
            exp_sub = {vecs[i].pcwrite, vecs[i].regwrite, vecs[i].branch, vecs[i].branch_ne,
                       vecs[i].pcsrc, vecs[i].regdst, vecs[i].memtoreg, vecs[i].aluop};
            chk($sformatf("vec%0d_state", i), 32'(o_state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_ctl", i), 32'(got_sub), 32'(exp_sub));
            chk($sformatf("vec%0d_retired", i), 32'(o_retired), 32'(vecs[i].ret));
            tick();
        end

        // LW: 3 non-ready FETCH cycles (ready on the last allowed one), 2 non-ready MEM_READ cycles.
        // Edges after release: 1 IDLE + 4 FETCH + DECODE + MEM_ADR + 3 MEM_READ = 10 to reach MEM_WB.
        begin
            logic [9:0] pat;
            pat = 10'b1001110001;   // bit k = ready before edge k+1
            do_reset();
            i_opcode = OP_LW;
            pulses = 0;
            for (int k = 0; k < 10; k++) begin
                i_mem_ready = pat[k];
                #1;
                if (o_irwrite === 1'b1) pulses++;
                tick();
            end
            chk("lw_state_mem_wb", 32'(o_state), 32'(ST_MEM_WB));
            chk("lw_irwrite_pulses", 32'(pulses), 32'd1);
            chk("lw_memtoreg", 32'(o_memtoreg), 32'b01);
            chk("lw_regwrite", 32'(o_regwrite), 32'd1);
        end

        // Illegal opcode: trap with cause 01, sticky for 20 cycles, cleared by reset.
        do_reset();
        i_opcode = 6'b111111; i_mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("ill_state", 32'(o_state), 32'(ST_TRAP));
        chk("ill_trap", 32'(o_trap), 32'd1);
        chk("ill_cause", 32'(o_trap_cause), 32'b01);
        for (int k = 0; k < 20; k++) begin
            i_mem_ready = 1'($urandom);
            i_opcode = 6'($urandom);
            tick();
        end
        chk("ill_hold_state", 32'(o_state), 32'(ST_TRAP));
        chk("ill_hold_cause", 32'(o_trap_cause), 32'b01);
        chk("ill_hold_retired", 32'(o_retired), 32'd0);
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        #1;
        chk("ill_reset_state", 32'(o_state), 32'(ST_IDLE));
        chk("ill_reset_cause", 32'(o_trap_cause), 32'b00);

        // SW timeout: four non-ready MEM_WRITE cycles, last one drops the write and traps.
        go_to_mem_write();
        i_mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("to_memwrite_c%0d", k), 32'(o_memwrite), (k < 3) ? 32'd1 : 32'd0);
            tick();
        end
        chk("to_state", 32'(o_state), 32'(ST_TRAP));
        chk("to_cause", 32'(o_trap_cause), 32'b10);

        // Ready on the fourth MEM_WRITE cycle wins over the timeout.
        go_to_mem_write();
        i_mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        i_mem_ready = 1'b1;
        #1;
        chk("rw_memwrite_last", 32'(o_memwrite), 32'd1);
        ret_before = int'(o_retired);
        tick();
        chk("rw_state", 32'(o_state), 32'(ST_FETCH));
        chk("rw_trap", 32'(o_trap), 32'd0);
        chk("rw_retired", 32'(o_retired), 32'((ret_before + 1) % (1 << TB_RET_W)));

        // Eight ADDIs wrap a 3-bit retire counter.
        do_reset();
        i_opcode = OP_ADDI; i_mem_ready = 1'b1;
        tick();
        for (int n = 1; n <= 8; n++) begin
            for (int k = 0; k < 4; k++) tick();
            if (n == 7) chk("wrap_retired_7", 32'(o_retired), 32'd7);
        end
        chk("wrap_retired_0", 32'(o_retired), 32'd0);
        chk("wrap_state", 32'(o_state), 32'(ST_FETCH));

        // Reset during a pending MEM_WRITE aborts the write in the reset cycle and the next.
        go_to_mem_write();
        i_mem_ready = 1'b0;
        #1;
        chk("rst_mw_before", 32'(o_memwrite), 32'd1);
        tick();
        i_reset = 1'b0;
        #1;
        chk("rst_mw_reset_cycle", 32'(o_memwrite), 32'd0);
        tick();
        i_reset = 1'b1;
        #1;
        chk("rst_mw_state", 32'(o_state), 32'(ST_IDLE));
        chk("rst_mw_after", 32'(o_memwrite), 32'd0);

        // Random traffic against the model.
        burst = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (m_st == ST_TRAP) i_reset = ($urandom % 8) != 0;
            else                 i_reset = ($urandom % 300) != 0;
            if (m_st == ST_IDLE || m_st == ST_FETCH) i_opcode = ops[$urandom % 12];
            if (burst > 0) begin
                i_mem_ready = 1'b0;
                burst--;
            end else if ($urandom % 30 == 0) begin
                i_mem_ready = 1'b0;
                burst = $urandom_range(2, 6);
            end else begin
                i_mem_ready = ($urandom % 4) != 0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
